// File: rtl/i2s_mic_rx.sv
// I2S master receiver for a mono MEMS microphone. Generates BCLK/WS from HCLK,
// deserialises one slot of DIN (standard I2S, 1-bit delay, MSB first),
// sign-extends it and buffers it in a first-word-fall-through sample FIFO.
module i2s_mic_rx #(
   parameter int  CLK_DIV    = 4,
   parameter int  SAMPLE_W   = 24,
   parameter int  CHANNEL    = 0,
   parameter int  FIFO_DEPTH = 16,
   localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic             en,
   output logic             BCLK,
   output logic             WS,
   input  logic             DIN,
   output logic [31:0]      sample_data,
   output logic             sample_valid,
   input  logic             sample_ready,
   output logic [LVL_W-1:0] fifo_level,
   output logic             overrun,
   input  logic             clr_overrun
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int AW    = $clog2(FIFO_DEPTH);
   // 7-bit bounds so a right-slot range ending at bit 64 cannot alias to bit 0
   localparam logic [6:0]       FIRST_BIT = 7'(CHANNEL * 32 + 1);
   localparam logic [6:0]       LAST_BIT  = 7'(CHANNEL * 32 + SAMPLE_W);
   localparam logic [DIV_W-1:0] DIV_TC    = DIV_W'(CLK_DIV - 1);
   localparam logic [AW:0]      FULL_LVL  = (AW + 1)'(FIFO_DEPTH);

   logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
   logic                bclk_q, bclk_d;
   logic [5:0]          bit_cnt_q, bit_cnt_d;
   logic [SAMPLE_W-1:0] shift_q, shift_d;
   logic [AW:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic                overrun_q, overrun_d;
   logic [31:0]         mem_q [FIFO_DEPTH];

   logic                tc, rise, fall, cap, push;
   logic [SAMPLE_W-1:0] cap_val;
   logic [31:0]         word;
   logic [AW:0]         level;
   logic                empty, full, pop, wr_ok, drop;

   // Bit-clock events and capture window decode
   always_comb begin
      tc      = en && (div_cnt_q == DIV_TC);
      rise    = tc && !bclk_q;
      fall    = tc && bclk_q;
      cap     = rise && ({1'b0, bit_cnt_q} >= FIRST_BIT) && ({1'b0, bit_cnt_q} <= LAST_BIT);
      push    = rise && ({1'b0, bit_cnt_q} == LAST_BIT);
      // shift value including this cycle's DIN; becomes the pushed word on the last bit
      cap_val = SAMPLE_W'({shift_q, DIN});
      word    = 32'($signed(cap_val));
   end

   // Divider, frame counter and shifter next state; en=0 parks everything at zero
   always_comb begin
      div_cnt_d = div_cnt_q;
      bclk_d    = bclk_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      if (!en) begin
         div_cnt_d = '0;
         bclk_d    = 1'b0;
         bit_cnt_d = '0;
         shift_d   = '0;
      end else begin
         div_cnt_d = tc ? '0 : div_cnt_q + 1'b1;
         if (tc)   bclk_d    = ~bclk_q;
         if (fall) bit_cnt_d = bit_cnt_q + 6'd1;
         if (push)     shift_d = '0;
         else if (cap) shift_d = cap_val;
      end
   end

   // FIFO control: a push into a full FIFO only lands if a pop frees a slot this cycle
   always_comb begin
      level     = wr_ptr_q - rd_ptr_q;
      empty     = (level == '0);
      full      = (level == FULL_LVL);
      pop       = !empty && sample_ready;
      wr_ok     = push && (!full || pop);
      drop      = push && full && !pop;
      wr_ptr_d  = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      overrun_d = overrun_q;
      if (drop)             overrun_d = 1'b1;
      else if (clr_overrun) overrun_d = 1'b0;
   end

   // State registers
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         div_cnt_q <= '0;
         bclk_q    <= 1'b0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         overrun_q <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         bclk_q    <= bclk_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         overrun_q <= overrun_d;
      end
   end

   // Sample storage; no reset needed since the read port is gated by empty
   always_ff @(posedge HCLK) begin
      if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= word;
   end

   assign BCLK         = bclk_q;
   assign WS           = bit_cnt_q[5];
   assign sample_valid = !empty;
   assign sample_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   assign fifo_level   = level;
   assign overrun      = overrun_q;

endmodule
